// File: rtl/lsu_pkg.sv
// Shared definitions for the store path of the load/store unit:
// access-size encoding, sequencer state encoding and the size-to-byte-count
// lookup used by both the sequencer and its split calculator.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } st_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10
    } seq_state_e;

    // Bytes covered by an access; the illegal size maps to 0 so any
    // downstream math on it yields empty byte enables.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_store_split_calc.sv
// Combinational split calculator for one store request.
// Ports:
//   i_off    - low two bits of the store byte address
//   i_size   - access size encoding
//   i_data   - store data, LSB-first
//   o_split  - the access crosses a word boundary (two beats)
//   o_be0    - byte enables of beat 0
//   o_be1    - byte enables of beat 1 (zero when not split)
//   o_data1  - beat-1 data: store data shifted down by the beat-0 byte count
module lsu_store_split_calc
    import lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_data,
    output logic        o_split,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic [31:0] o_data1
);

    logic [2:0] w_nbytes;
    logic [2:0] w_end;
    logic [2:0] w_n0;
    logic [2:0] w_n1;
    logic [5:0] w_shamt;

    assign w_nbytes = nbytes(i_size);
    assign w_end    = {1'b0, i_off} + w_nbytes;
    assign o_split  = (w_end > 3'd4);
    assign w_n0     = o_split ? (3'd4 - {1'b0, i_off}) : w_nbytes;
    assign w_n1     = w_nbytes - w_n0;

    // A 5-bit intermediate lets a count of 4 produce 4'b1111.
    assign o_be0    = 4'((5'd1 << w_n0) - 5'd1);
    assign o_be1    = 4'((5'd1 << w_n1) - 5'd1);

    // Shift of 32 (n0 = 4) drains the word to zero.
    assign w_shamt  = {w_n0, 3'b000};
    assign o_data1  = i_data >> w_shamt;

endmodule

// File: rtl/lsu_store_sequencer.sv
// Store sequencer: accepts one store request at a time and emits one or two
// aligned-word write beats downstream, splitting accesses that cross a word
// boundary. Illegal sizes are rejected with a one-cycle error pulse.
// Ports:
//   i_clk, i_reset            - clock, synchronous active-high reset
//   i_st_valid / o_st_ready   - store request handshake
//   i_st_addr/data/size       - store request fields
//   o_wr_valid / i_wr_ready   - write beat handshake
//   o_wr_addr/o_wdata/o_byte_en - write beat fields
//   o_addr_0                  - odd/even bank-swap select (o_wr_addr[0])
//   o_st_err                  - pulse on acceptance of an illegal size
//   o_split                   - in-flight store is a two-beat store
//
// state    | meaning
// ST_IDLE  | ready for a request, no beat presented
// ST_BEAT0 | first (or only) beat presented, waiting for i_wr_ready
// ST_BEAT1 | second beat of a split store presented
module lsu_store_sequencer
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_st_valid,
    output logic              o_st_ready,
    input  logic [ADDR_W-1:0] i_st_addr,
    input  logic [31:0]       i_st_data,
    input  logic [1:0]        i_st_size,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wdata,
    output logic              o_addr_0,
    output logic [3:0]        o_byte_en,
    output logic              o_st_err,
    output logic              o_split
);

    seq_state_e        r_state;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_byte_en;
    logic              r_st_err;
    logic              r_split;
    // Beat-1 fields captured at acceptance so the request bus is free after.
    logic [ADDR_W-1:0] r_b1_addr;
    logic [31:0]       r_b1_data;
    logic [3:0]        r_b1_be;

    logic              w_split;
    logic [3:0]        w_be0;
    logic [3:0]        w_be1;
    logic [31:0]       w_data1;
    logic [ADDR_W-1:0] w_b1_addr;

    lsu_store_split_calc u_split_calc (
        .i_off   (i_st_addr[1:0]),
        .i_size  (i_st_size),
        .i_data  (i_st_data),
        .o_split (w_split),
        .o_be0   (w_be0),
        .o_be1   (w_be1),
        .o_data1 (w_data1)
    );

    // Wraps modulo 2^ADDR_W by truncation.
    assign w_b1_addr = {i_st_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wdata    <= '0;
            r_byte_en  <= '0;
            r_st_err   <= 1'b0;
            r_split    <= 1'b0;
            r_b1_addr  <= '0;
            r_b1_data  <= '0;
            r_b1_be    <= '0;
        end else begin
            r_st_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_st_valid) begin
                        if (i_st_size == SZ_ILLEGAL) begin
                            r_st_err <= 1'b1;
                        end else begin
                            r_state    <= ST_BEAT0;
                            r_wr_valid <= 1'b1;
                            r_wr_addr  <= i_st_addr;
                            r_wdata    <= i_st_data;
                            r_byte_en  <= w_be0;
                            r_split    <= w_split;
                            r_b1_addr  <= w_b1_addr;
                            r_b1_data  <= w_data1;
                            r_b1_be    <= w_be1;
                        end
                    end
                end
                ST_BEAT0: begin
                    if (i_wr_ready) begin
                        if (r_split) begin
                            r_state   <= ST_BEAT1;
                            r_wr_addr <= r_b1_addr;
                            r_wdata   <= r_b1_data;
                            r_byte_en <= r_b1_be;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_wr_valid <= 1'b0;
                            r_byte_en  <= '0;
                            r_split    <= 1'b0;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (i_wr_ready) begin
                        r_state    <= ST_IDLE;
                        r_wr_valid <= 1'b0;
                        r_byte_en  <= '0;
                        r_split    <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wr_valid <= 1'b0;
                    r_byte_en  <= '0;
                    r_split    <= 1'b0;
                end
            endcase
        end
    end

    assign o_st_ready = (r_state == ST_IDLE);
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wdata    = r_wdata;
    assign o_addr_0   = r_wr_addr[0];
    assign o_byte_en  = r_byte_en;
    assign o_st_err   = r_st_err;
    assign o_split    = r_split;

endmodule

// File: tb/tb_lsu_store_sequencer.sv
// Directed bench for lsu_store_sequencer with a beat scoreboard.
module tb_lsu_store_sequencer;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_st_valid = 1'b0;
    logic        o_st_ready;
    logic [31:0] i_st_addr = '0;
    logic [31:0] i_st_data = '0;
    logic [1:0]  i_st_size = '0;
    logic        o_wr_valid;
    logic        i_wr_ready = 1'b1;
    logic [31:0] o_wr_addr;
    logic [31:0] o_wdata;
    logic        o_addr_0;
    logic [3:0]  o_byte_en;
    logic        o_st_err;
    logic        o_split;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        split;
    } beat_t;

    beat_t exp_q[$];

    lsu_store_sequencer #(.ADDR_W(32)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_st_valid (i_st_valid),
        .o_st_ready (o_st_ready),
        .i_st_addr  (i_st_addr),
        .i_st_data  (i_st_data),
        .i_st_size  (i_st_size),
        .o_wr_valid (o_wr_valid),
        .i_wr_ready (i_wr_ready),
        .o_wr_addr  (o_wr_addr),
        .o_wdata    (o_wdata),
        .o_addr_0   (o_addr_0),
        .o_byte_en  (o_byte_en),
        .o_st_err   (o_st_err),
        .o_split    (o_split)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: push the beats a legal store is expected to produce.
    task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int nb, off, n0, n1;
        bit sp;
        beat_t b;
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        off = int'(a[1:0]);
        sp  = (off + nb) > 4;
        n0  = sp ? 4 - off : nb;
        n1  = nb - n0;
        b.addr = a; b.data = d; b.split = sp; b.be = '0;
        for (int i = 0; i < n0; i++) b.be[i] = 1'b1;
        exp_q.push_back(b);
        if (sp) begin
            b.addr = (a & 32'hFFFF_FFFC) + 32'd4;
            b.data = (n0 == 4) ? 32'd0 : (d >> (8 * n0));
            b.be   = '0;
            for (int i = 0; i < n1; i++) b.be[i] = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    // Present a store and wait for it to be accepted; returns 1 time unit
    // after the accepting edge with i_st_valid dropped.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        i_st_valid = 1'b1;
        i_st_addr  = a;
        i_st_data  = d;
        i_st_size  = sz;
        for (int k = 0; k < 20; k++) begin
            if (o_st_ready === 1'b1) break;
            @(posedge clk); #1;
        end
        chk("st_ready_wait", {63'd0, o_st_ready}, 64'd1);
        if (sz != 2'b11) push_exp(a, d, sz);
        @(posedge clk); #1;
        i_st_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0 && o_st_ready === 1'b1 && o_wr_valid === 1'b0) break;
            @(posedge clk); #1;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every presented beat must match the queue head, every
    // cycle it is held; it is retired when downstream is ready.
    always @(negedge clk) begin
        if (o_wr_valid === 1'b1) begin
            chk("beat_pending", {63'd0, exp_q.size() > 0}, 64'd1);
            if (exp_q.size() > 0) begin
                chk("wr_addr", {32'd0, o_wr_addr}, {32'd0, exp_q[0].addr});
                chk("wdata",   {32'd0, o_wdata},   {32'd0, exp_q[0].data});
                chk("byte_en", {60'd0, o_byte_en}, {60'd0, exp_q[0].be});
                chk("addr_0",  {63'd0, o_addr_0},  {63'd0, exp_q[0].addr[0]});
                chk("split",   {63'd0, o_split},   {63'd0, exp_q[0].split});
                if (i_wr_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_valid", {63'd0, o_wr_valid}, 64'd0);
        chk("rst_wr_addr",  {32'd0, o_wr_addr},  64'd0);
        chk("rst_wdata",    {32'd0, o_wdata},    64'd0);
        chk("rst_byte_en",  {60'd0, o_byte_en},  64'd0);
        chk("rst_st_err",   {63'd0, o_st_err},   64'd0);
        chk("rst_split",    {63'd0, o_split},    64'd0);
        chk("rst_st_ready", {63'd0, o_st_ready}, 64'd1);
        i_reset = 1'b0;
        @(posedge clk); #1;

        // Word store, aligned, single beat
        store(32'h0000_0100, 32'hAABB_CCDD, 2'b10);
        chk("word_split", {63'd0, o_split}, 64'd0);
        chk("word_valid", {63'd0, o_wr_valid}, 64'd1);
        wait_idle();

        // Half store crossing a word boundary
        store(32'h0000_0103, 32'h0000_1122, 2'b01);
        chk("half_split", {63'd0, o_split}, 64'd1);
        wait_idle();

        // Word store at offset 2 with downstream back-pressure
        i_wr_ready = 1'b0;
        store(32'h0000_0202, 32'h1122_3344, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_valid", {63'd0, o_wr_valid}, 64'd1);
        chk("stall_be",    {60'd0, o_byte_en},  64'h3);
        i_wr_ready = 1'b1;
        wait_idle();

        // Illegal size: error pulse only
        store(32'h0000_0300, 32'hDEAD_BEEF, 2'b11);
        chk("err_pulse", {63'd0, o_st_err},   64'd1);
        chk("err_valid", {63'd0, o_wr_valid}, 64'd0);
        chk("err_ready", {63'd0, o_st_ready}, 64'd1);
        @(posedge clk); #1;
        chk("err_clear", {63'd0, o_st_err},   64'd0);
        chk("err_valid2", {63'd0, o_wr_valid}, 64'd0);

        // Reset while beat 1 is pending; beat 1 must never appear
        store(32'h0000_0103, 32'h0000_5566, 2'b01);
        @(posedge clk); #1;
        i_wr_ready = 1'b0;
        i_reset    = 1'b1;
        @(posedge clk); #1;
        i_reset    = 1'b0;
        i_wr_ready = 1'b1;
        exp_q.delete();
        chk("rst_b1_valid", {63'd0, o_wr_valid}, 64'd0);
        chk("rst_b1_ready", {63'd0, o_st_ready}, 64'd1);
        chk("rst_b1_split", {63'd0, o_split},    64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_b1_quiet", {63'd0, o_wr_valid}, 64'd0);

        // Address wrap on beat 1
        store(32'hFFFF_FFFE, 32'h1122_3344, 2'b10);
        wait_idle();

        // Byte stores and a few random legal stores back to back
        store(32'h0000_0403, 32'h0000_0055, 2'b00);
        store(32'h0000_0402, 32'h0000_A1B2, 2'b01);
        for (int r = 0; r < 6; r++) begin
            store($urandom, $urandom, 2'($urandom_range(0, 2)));
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
